// File: rtl/ad_sample_ctrl.sv
// AD conversion sequencer: runs N cycles of (W idle clocks + L convert strobes spaced CONV_DIV apart).
// Run parameters are latched at start so that mid-run changes on the UART side have no effect.
module ad_sample_ctrl #(
    parameter int CONV_DIV = 10
) (
    input  logic        I_clk_10M,
    input  logic        I_rst,
    input  logic [31:0] I_cycle_num,
    input  logic [31:0] I_sample_length,
    input  logic [31:0] I_wait_time,
    input  logic        I_start,
    input  logic        I_abort,
    output logic        O_ad_conv,
    output logic        O_busy,
    output logic        O_done,
    output logic [31:0] O_cycle_cnt,
    output logic [31:0] O_sample_cnt
);

    localparam int DIV_W = $clog2(CONV_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CONV_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_n;
    logic [31:0]      r_l;
    logic [31:0]      r_w;
    logic [31:0]      r_waitCnt;
    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_cycleCnt;
    logic [31:0]      r_sampleCnt;
    logic             r_conv;
    logic             r_busy;
    logic             r_done;

    state_t           w_nextState;
    logic [31:0]      w_n;
    logic [31:0]      w_l;
    logic [31:0]      w_w;
    logic [31:0]      w_waitCnt;
    logic [DIV_W-1:0] w_div;
    logic [31:0]      w_cycleCnt;
    logic [31:0]      w_sampleCnt;
    logic             w_conv;
    logic             w_enterSample;
    logic [31:0]      w_cycleInc;

    assign w_cycleInc = r_cycleCnt + 32'd1;

    // Next-state logic computes the values every output register takes at the next edge,
    // so strobe and counters appear in the same cycle the state enters them.
    always_comb begin
        w_nextState   = r_state;
        w_n           = r_n;
        w_l           = r_l;
        w_w           = r_w;
        w_waitCnt     = r_waitCnt;
        w_div         = r_div;
        w_cycleCnt    = r_cycleCnt;
        w_sampleCnt   = r_sampleCnt;
        w_conv        = 1'b0;
        w_enterSample = 1'b0;

        if (I_abort) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_start) begin
                        w_n         = I_cycle_num;
                        w_l         = I_sample_length;
                        w_w         = I_wait_time;
                        w_cycleCnt  = 32'd0;
                        w_sampleCnt = 32'd0;
                        if (I_cycle_num == 32'd0 || I_sample_length == 32'd0) begin
                            w_nextState = S_DONE;
                        end else if (I_wait_time == 32'd0) begin
                            w_enterSample = 1'b1;
                        end else begin
                            w_nextState = S_WAIT;
                            w_waitCnt   = 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_waitCnt == r_w) begin
                        w_enterSample = 1'b1;
                    end else begin
                        w_waitCnt = r_waitCnt + 32'd1;
                    end
                end
                S_SAMPLE: begin
                    if (r_div == DIV_LAST) begin
                        // Last clock of a slot: either the burst is over or the next slot strobes
                        if (r_sampleCnt == r_l) begin
                            w_cycleCnt = w_cycleInc;
                            if (w_cycleInc == r_n) begin
                                w_nextState = S_DONE;
                            end else if (r_w == 32'd0) begin
                                w_enterSample = 1'b1;
                            end else begin
                                w_nextState = S_WAIT;
                                w_waitCnt   = 32'd1;
                            end
                        end else begin
                            w_div       = '0;
                            w_sampleCnt = r_sampleCnt + 32'd1;
                            w_conv      = 1'b1;
                        end
                    end else begin
                        w_div = r_div + 1'b1;
                    end
                end
                S_DONE: begin
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase

            if (w_enterSample) begin
                w_nextState = S_SAMPLE;
                w_div       = '0;
                w_sampleCnt = 32'd1;
                w_conv      = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk_10M or posedge I_rst) begin
        if (I_rst) begin
            r_state     <= S_IDLE;
            r_n         <= 32'd0;
            r_l         <= 32'd0;
            r_w         <= 32'd0;
            r_waitCnt   <= 32'd0;
            r_div       <= '0;
            r_cycleCnt  <= 32'd0;
            r_sampleCnt <= 32'd0;
            r_conv      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_n         <= w_n;
            r_l         <= w_l;
            r_w         <= w_w;
            r_waitCnt   <= w_waitCnt;
            r_div       <= w_div;
            r_cycleCnt  <= w_cycleCnt;
            r_sampleCnt <= w_sampleCnt;
            r_conv      <= w_conv;
            r_busy      <= (w_nextState == S_WAIT) || (w_nextState == S_SAMPLE);
            r_done      <= (w_nextState == S_DONE);
        end
    end

    assign O_ad_conv    = r_conv;
    assign O_busy       = r_busy;
    assign O_done       = r_done;
    assign O_cycle_cnt  = r_cycleCnt;
    assign O_sample_cnt = r_sampleCnt;

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// Self-checking bench for ad_sample_ctrl: directed scenarios plus random runs,
// with expected strobes/counts derived from the run-timing formulas of the sequencer.
module tb_ad_sample_ctrl;

    localparam int D = 10;

    logic        clock;
    logic        rst;
    logic [31:0] cycleNum;
    logic [31:0] sampleLength;
    logic [31:0] waitTime;
    logic        start;
    logic        abort;
    logic        adConv;
    logic        busy;
    logic        done;
    logic [31:0] cycleCnt;
    logic [31:0] sampleCnt;

    int checks = 0;
    int errors = 0;

    ad_sample_ctrl #(.CONV_DIV(D)) dut (
        .I_clk_10M      (clock),
        .I_rst          (rst),
        .I_cycle_num    (cycleNum),
        .I_sample_length(sampleLength),
        .I_wait_time    (waitTime),
        .I_start        (start),
        .I_abort        (abort),
        .O_ad_conv      (adConv),
        .O_busy         (busy),
        .O_done         (done),
        .O_cycle_cnt    (cycleCnt),
        .O_sample_cnt   (sampleCnt)
    );

    // 10 MHz clock
    initial clock = 1'b0;
    always #50 clock = ~clock;

    // One comparison point: counts it and reports a failure with tag and both values
    task automatic checkOutput(input string tag, input int rel, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at rel=%0d: observed=%0h expected=%0h", tag, rel, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs and samples both sit 1 time unit after the rising edge
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Present run parameters together with a start request for the current cycle
    task automatic applyStimulus(input int n, input int l, input int w, input logic ab);
        cycleNum     = 32'(n);
        sampleLength = 32'(l);
        waitTime     = 32'(w);
        start        = 1'b1;
        abort        = ab;
    endtask

    // Reference: counters frozen at relative cycle t (t >= 1) of a run with the given parameters
    task automatic modelCounts(input int n, input int l, input int w, input int t,
                               output int expCyc, output int expSmp);
        int p, x, c, r;
        p = w + l * D;
        if (n == 0 || l == 0) begin
            expCyc = 0;
            expSmp = 0;
        end else begin
            x = t - 1;
            c = x / p;
            r = x % p;
            if (c >= n) begin
                expCyc = n;
                expSmp = l;
            end else begin
                expCyc = c;
                if (r < w) expSmp = (c == 0) ? 0 : l;
                else       expSmp = (r - w) / D + 1;
            end
        end
    endtask

    // Start a run at the current cycle and check every cycle until it has settled back to idle.
    // abortAt > 0 asserts abort during that relative cycle; chaos scrambles parameters and start while busy.
    task automatic runAndCheck(input int n, input int l, input int w, input int abortAt, input bit chaos);
        int  p, doneRel, lastRel, x, c, r, eCyc, eSmp;
        bit  zero, expConv, expBusy, expDone;
        p       = w + l * D;
        zero    = (n == 0 || l == 0);
        doneRel = zero ? 1 : 1 + n * p;
        lastRel = (abortAt > 0) ? abortAt + 2 : doneRel + 2;
        applyStimulus(n, l, w, 1'b0);
        nextCycle();
        start = 1'b0;
        for (int rel = 1; rel <= lastRel; rel++) begin
            if (abortAt > 0 && rel > abortAt) begin
                expConv = 1'b0;
                expBusy = 1'b0;
                expDone = 1'b0;
            end else begin
                x       = rel - 1;
                c       = zero ? 0 : x / p;
                r       = zero ? 0 : x % p;
                expConv = !zero && c < n && r >= w && ((r - w) % D) == 0;
                expBusy = !zero && rel <= n * p;
                expDone = (rel == doneRel);
            end
            checkOutput("conv", rel, 32'(adConv), 32'(expConv));
            checkOutput("busy", rel, 32'(busy), 32'(expBusy));
            checkOutput("done", rel, 32'(done), 32'(expDone));
            abort = (rel == abortAt);
            if (chaos && rel < doneRel && !(abortAt > 0 && rel >= abortAt)) begin
                cycleNum     = $urandom_range(0, 5);
                sampleLength = $urandom_range(0, 5);
                waitTime     = $urandom_range(0, 8);
                start        = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            nextCycle();
        end
        abort = 1'b0;
        start = 1'b0;
        modelCounts(n, l, w, (abortAt > 0) ? abortAt : doneRel, eCyc, eSmp);
        checkOutput("cycle_cnt", lastRel, cycleCnt, 32'(eCyc));
        checkOutput("sample_cnt", lastRel, sampleCnt, 32'(eSmp));
    endtask

    initial begin
        int n, l, w, ab;
        rst          = 1'b1;
        cycleNum     = '0;
        sampleLength = '0;
        waitTime     = '0;
        start        = 1'b0;
        abort        = 1'b0;

        // Reset values
        #120;
        checkOutput("rst_conv", 0, 32'(adConv), 32'd0);
        checkOutput("rst_busy", 0, 32'(busy), 32'd0);
        checkOutput("rst_done", 0, 32'(done), 32'd0);
        checkOutput("rst_cycle", 0, cycleCnt, 32'd0);
        checkOutput("rst_sample", 0, sampleCnt, 32'd0);
        @(negedge clock);
        rst = 1'b0;
        nextCycle();

        // Reset mid-SAMPLE clears outputs without waiting for a clock edge
        applyStimulus(2, 3, 5, 1'b0);
        nextCycle();
        start = 1'b0;
        for (int i = 1; i < 7; i++) nextCycle();
        checkOutput("pre_rst_conv", 7, 32'(adConv), 32'd0);
        checkOutput("pre_rst_sample", 7, sampleCnt, 32'd1);
        #20;
        rst = 1'b1;
        #1;
        checkOutput("async_conv", 7, 32'(adConv), 32'd0);
        checkOutput("async_busy", 7, 32'(busy), 32'd0);
        checkOutput("async_done", 7, 32'(done), 32'd0);
        checkOutput("async_sample", 7, sampleCnt, 32'd0);
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("post_rst_busy", i, 32'(busy), 32'd0);
            checkOutput("post_rst_conv", i, 32'(adConv), 32'd0);
        end

        // Directed scenarios: nominal, no wait, zero cases, abort, mid-run changes
        runAndCheck(2, 3, 5, 0, 1'b0);
        runAndCheck(1, 2, 0, 0, 1'b0);
        runAndCheck(0, 3, 4, 0, 1'b0);
        runAndCheck(2, 0, 4, 0, 1'b0);
        runAndCheck(2, 3, 5, 26, 1'b0);

        // Start together with abort in IDLE must not start a run; counters keep aborted values
        applyStimulus(2, 3, 5, 1'b1);
        nextCycle();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checkOutput("startabort_busy", i, 32'(busy), 32'd0);
            checkOutput("startabort_conv", i, 32'(adConv), 32'd0);
            nextCycle();
        end
        checkOutput("startabort_sample", 4, sampleCnt, 32'd3);
        checkOutput("startabort_cycle", 4, cycleCnt, 32'd0);

        runAndCheck(2, 3, 5, 0, 1'b1);

        // Randomized runs
        for (int run = 0; run < 30; run++) begin
            n  = $urandom_range(0, 3);
            l  = $urandom_range(0, 4);
            w  = $urandom_range(0, 6);
            ab = 0;
            if (n != 0 && l != 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, n * (w + l * D));
            runAndCheck(n, l, w, ab, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
